// File: rtl/async_fifo_pkg.sv
// Shared helpers for the dual-clock Gray-pointer FIFO:
// pointer code conversion and parameter sanity checks.
package async_fifo_pkg;

  localparam int GW = 32;

  function automatic logic [GW-1:0] bin2gray(
    input logic [GW-1:0] b
  );
    return b ^ (b >> 1);
  endfunction

  // Zero-extended inputs convert correctly at any narrower width.
  function automatic logic [GW-1:0] gray2bin(
    input logic [GW-1:0] g
  );
    logic [GW-1:0] b;
    b[GW-1] = g[GW-1];
    for (int i = GW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic bit cfg_ok(
    input int addr_w,
    input int sync_stages,
    input int afull_th,
    input int aempty_th,
    input int fwft
  );
    return addr_w >= 2 && addr_w < GW - 1
      && sync_stages >= 2
      && afull_th >= 1
      && afull_th <= (1 << addr_w)
      && aempty_th >= 0
      && aempty_th <= (1 << addr_w) - 1
      && (fwft == 0 || fwft == 1);
  endfunction

endpackage

// File: rtl/async_fifo_gray_cdc_sync_bus.sv
// Multi-flop synchroniser for a Gray-coded pointer bus;
// only one bit changes per source update, so bus skew is safe.
module cdc_sync_bus #(
  parameter int W      = 1,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] chain [STAGES];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < STAGES; i++) begin
        chain[i] <= '0;
      end
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        chain[i] <= chain[i-1];
      end
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/async_fifo_gray.sv
// Dual-clock FIFO with Gray pointers, level/almost flags,
// error pulses and optional first-word-fall-through output.
module async_fifo_gray
  import async_fifo_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int AFULL_TH    = 12,
  parameter int AEMPTY_TH   = 2,
  parameter int FWFT        = 0
) (
  input  logic              wr_clk,
  input  logic              rd_clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              full,
  output logic              almost_full,
  output logic [ADDR_W:0]   wr_level,
  output logic              overflow,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              empty,
  output logic              almost_empty,
  output logic [ADDR_W:0]   rd_level,
  output logic              underflow
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef logic [ADDR_W:0] ptr_t;

  localparam ptr_t AFULL_P  = ptr_t'(AFULL_TH);
  localparam ptr_t AEMPTY_P = ptr_t'(AEMPTY_TH);

  if (!cfg_ok(ADDR_W, SYNC_STAGES, AFULL_TH,
              AEMPTY_TH, FWFT)) begin : g_cfg_err
    $error("async_fifo_gray: bad parameters");
  end

  logic [DATA_W-1:0] mem [DEPTH];

  ptr_t wr_bin, wr_gray, rq_gray;
  ptr_t wr_bin_nx, wr_gray_nx, rq_bin, wr_lvl_nx;
  ptr_t rd_bin, rd_gray, wq_gray;
  ptr_t rd_bin_nx, rd_gray_nx, wq_bin, rd_lvl_nx;
  logic wr_push, full_nx;
  logic rd_pop, mem_empty;

  // Write domain
  assign wr_push    = wr_en && !full;
  assign wr_bin_nx  = wr_bin + ptr_t'(wr_push);
  assign wr_gray_nx = ptr_t'(bin2gray(32'(wr_bin_nx)));
  assign rq_bin     = ptr_t'(gray2bin(32'(rq_gray)));
  assign wr_lvl_nx  = wr_bin_nx - rq_bin;
  assign full_nx    = wr_gray_nx ==
    {~rq_gray[ADDR_W -: 2], rq_gray[ADDR_W-2:0]};

  always_ff @(posedge wr_clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_bin      <= '0;
      wr_gray     <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      wr_level    <= '0;
      overflow    <= 1'b0;
    end else begin
      wr_bin      <= wr_bin_nx;
      wr_gray     <= wr_gray_nx;
      full        <= full_nx;
      almost_full <= wr_lvl_nx >= AFULL_P;
      wr_level    <= wr_lvl_nx;
      overflow    <= wr_en && full;
    end
  end

  always_ff @(posedge wr_clk) begin
    if (wr_push) begin
      mem[wr_bin[ADDR_W-1:0]] <= wr_data;
    end
  end

  cdc_sync_bus #(
    .W      (ADDR_W + 1),
    .STAGES (SYNC_STAGES)
  ) u_sync_rd2wr (
    .clk     (wr_clk),
    .reset_n (reset_n),
    .d       (rd_gray),
    .q       (rq_gray)
  );

  cdc_sync_bus #(
    .W      (ADDR_W + 1),
    .STAGES (SYNC_STAGES)
  ) u_sync_wr2rd (
    .clk     (rd_clk),
    .reset_n (reset_n),
    .d       (wr_gray),
    .q       (wq_gray)
  );

  // Read domain: pointer, memory-empty and level
  assign rd_bin_nx  = rd_bin + ptr_t'(rd_pop);
  assign rd_gray_nx = ptr_t'(bin2gray(32'(rd_bin_nx)));
  assign wq_bin     = ptr_t'(gray2bin(32'(wq_gray)));
  assign rd_lvl_nx  = wq_bin - rd_bin_nx;

  always_ff @(posedge rd_clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_bin       <= '0;
      rd_gray      <= '0;
      mem_empty    <= 1'b1;
      rd_level     <= '0;
      almost_empty <= 1'b1;
    end else begin
      rd_bin       <= rd_bin_nx;
      rd_gray      <= rd_gray_nx;
      mem_empty    <= rd_gray_nx == wq_gray;
      rd_level     <= rd_lvl_nx;
      almost_empty <= rd_lvl_nx <= AEMPTY_P;
    end
  end

  if (FWFT != 0) begin : g_fwft
    // Head register refills whenever it is free or being popped.
    assign rd_pop = !mem_empty && (!rd_valid || rd_en);
    assign empty  = !rd_valid;

    always_ff @(posedge rd_clk or negedge reset_n) begin
      if (!reset_n) begin
        rd_valid  <= 1'b0;
        rd_data   <= '0;
        underflow <= 1'b0;
      end else begin
        underflow <= rd_en && !rd_valid;
        if (rd_pop) begin
          rd_valid <= 1'b1;
          rd_data  <= mem[rd_bin[ADDR_W-1:0]];
        end else if (rd_en) begin
          rd_valid <= 1'b0;
        end
      end
    end
  end else begin : g_std
    assign rd_pop = rd_en && !mem_empty;
    assign empty  = mem_empty;

    always_ff @(posedge rd_clk or negedge reset_n) begin
      if (!reset_n) begin
        rd_valid  <= 1'b0;
        rd_data   <= '0;
        underflow <= 1'b0;
      end else begin
        rd_valid  <= rd_pop;
        underflow <= rd_en && mem_empty;
        if (rd_pop) begin
          rd_data <= mem[rd_bin[ADDR_W-1:0]];
        end
      end
    end
  end

endmodule

// File: tb/tb_async_fifo_gray.sv
// Scoreboard bench: FWFT=1 instance for latency, reset and
// random streaming; FWFT=0 instance for fill, drain, pops.
`timescale 1ns/100ps
module tb_async_fifo_gray;

  localparam int SYNC = 2;

  logic wr_clk = 1'b0;
  logic rd_clk = 1'b0;
  logic reset_n;
  real  wr_half = 5.0;
  real  rd_half = 13.5;

  always #(wr_half) wr_clk = ~wr_clk;
  always #(rd_half) rd_clk = ~rd_clk;

  logic        wr_en, full, almost_full, overflow;
  logic [31:0] wr_data, rd_data;
  logic [4:0]  wr_level, rd_level;
  logic        rd_en, rd_valid, empty;
  logic        almost_empty, underflow;

  logic        wr_en0, full0, almost_full0, overflow0;
  logic [31:0] wr_data0, rd_data0;
  logic [4:0]  wr_level0, rd_level0;
  logic        rd_en0, rd_valid0, empty0;
  logic        almost_empty0, underflow0;

  async_fifo_gray #(
    .DATA_W(32), .ADDR_W(4), .SYNC_STAGES(SYNC),
    .AFULL_TH(12), .AEMPTY_TH(2), .FWFT(1)
  ) u_dut (
    .wr_clk(wr_clk), .rd_clk(rd_clk),
    .reset_n(reset_n),
    .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .almost_full(almost_full),
    .wr_level(wr_level), .overflow(overflow),
    .rd_en(rd_en), .rd_data(rd_data),
    .rd_valid(rd_valid), .empty(empty),
    .almost_empty(almost_empty),
    .rd_level(rd_level), .underflow(underflow)
  );

  async_fifo_gray #(
    .DATA_W(32), .ADDR_W(4), .SYNC_STAGES(SYNC),
    .AFULL_TH(12), .AEMPTY_TH(2), .FWFT(0)
  ) u_dut0 (
    .wr_clk(wr_clk), .rd_clk(rd_clk),
    .reset_n(reset_n),
    .wr_en(wr_en0), .wr_data(wr_data0),
    .full(full0), .almost_full(almost_full0),
    .wr_level(wr_level0), .overflow(overflow0),
    .rd_en(rd_en0), .rd_data(rd_data0),
    .rd_valid(rd_valid0), .empty(empty0),
    .almost_empty(almost_empty0),
    .rd_level(rd_level0), .underflow(underflow0)
  );

  int checks = 0;
  int errors = 0;
  int rx1    = 0;
  int v0_cnt = 0;
  logic [31:0] q1 [$];
  logic [31:0] q0 [$];

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // Monitors: pop the expected word whenever data leaves a DUT
  always @(negedge rd_clk) begin
    if (reset_n && rd_en && rd_valid) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL fwft_unexpected got=%h exp=none",
                 rd_data);
      end else begin
        chk("fwft_data", rd_data, q1.pop_front());
      end
      rx1++;
    end
  end

  always @(negedge rd_clk) begin
    if (reset_n && rd_valid0) begin
      if (q0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL std_unexpected got=%h exp=none",
                 rd_data0);
      end else begin
        chk("std_data", rd_data0, q0.pop_front());
      end
      v0_cnt++;
    end
  end

  task automatic w1(input logic [31:0] d,
                    output bit acc);
    @(posedge wr_clk);
    #1;
    wr_en   = 1'b1;
    wr_data = d;
    @(negedge wr_clk);
    acc = !full;
    if (acc) q1.push_back(d);
    @(posedge wr_clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic w0(input logic [31:0] d,
                    output bit acc);
    @(posedge wr_clk);
    #1;
    wr_en0   = 1'b1;
    wr_data0 = d;
    @(negedge wr_clk);
    acc = !full0;
    if (acc) q0.push_back(d);
    @(posedge wr_clk);
    #1;
    wr_en0 = 1'b0;
  endtask

  task automatic pop1(input string nm);
    int k;
    for (k = 0; k < 20 && !rd_valid; k++) begin
      @(posedge rd_clk);
      #1;
    end
    chk(nm, rd_valid, 1'b1);
    @(posedge rd_clk);
    #1;
    rd_en = 1'b1;
    @(posedge rd_clk);
    #1;
    rd_en = 1'b0;
  endtask

  task automatic run_stream(input int n,
                            input logic [31:0] seed);
    int sent, wc, rc, base;
    logic [31:0] nxt;
    sent = 0;
    wc   = 0;
    rc   = 0;
    base = rx1;
    nxt  = seed;
    fork
      begin
        while (sent < n && wc < 20000) begin
          @(posedge wr_clk);
          #1;
          wr_en   = 1'($urandom_range(0, 1));
          wr_data = nxt;
          @(negedge wr_clk);
          if (wr_en && !full) begin
            q1.push_back(nxt);
            nxt++;
            sent++;
          end
          wc++;
        end
        @(posedge wr_clk);
        #1;
        wr_en = 1'b0;
      end
      begin
        while (rx1 - base < n && rc < 40000) begin
          @(posedge rd_clk);
          #1;
          rd_en = 1'($urandom_range(0, 1));
          rc++;
        end
        rd_en = 1'b0;
      end
    join
    chk("stream_sent", sent, n);
    chk("stream_rx", rx1 - base, n);
    chk("stream_left", q1.size(), 0);
  endtask

  logic [31:0] fill_d [17];
  bit acc;
  int found, v0_base, k;

  initial begin
    reset_n  = 1'b0;
    wr_en    = 1'b0;
    wr_data  = '0;
    rd_en    = 1'b0;
    wr_en0   = 1'b0;
    wr_data0 = '0;
    rd_en0   = 1'b0;
    #30;
    chk("rst_empty", empty, 1'b1);
    chk("rst_aempty", almost_empty, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_afull", almost_full, 1'b0);
    chk("rst_valid", rd_valid, 1'b0);
    chk("rst_wlvl", wr_level, 0);
    chk("rst_rlvl", rd_level, 0);
    chk("rst_rdata", rd_data, 0);
    chk("rst_empty0", empty0, 1'b1);
    chk("rst_valid0", rd_valid0, 1'b0);
    #7;
    reset_n = 1'b1;
    repeat (4) @(posedge rd_clk);
    #1;
    chk("idle_empty", empty, 1'b1);
    chk("idle_ovf", overflow, 1'b0);
    chk("idle_udf", underflow, 1'b0);

    // Fill the registered-read instance to capacity
    for (int i = 1; i <= 16; i++) begin
      fill_d[i] = $urandom;
      w0(fill_d[i], acc);
      chk("fill_acc", acc, 1'b1);
      chk("fill_wlvl", wr_level0, i);
      chk("fill_afull", almost_full0, i >= 12);
      chk("fill_full", full0, i == 16);
    end
    w0(32'hDEAD_BEEF, acc);
    chk("ovf_drop", acc, 1'b0);
    chk("ovf_pulse", overflow0, 1'b1);
    chk("ovf_wlvl", wr_level0, 16);
    @(posedge wr_clk);
    #1;
    chk("ovf_end", overflow0, 1'b0);

    // Drain 16, then one read past empty
    repeat (10) @(posedge rd_clk);
    #1;
    chk("pre_drain_rlvl", rd_level0, 16);
    chk("pre_drain_aempty", almost_empty0, 1'b0);
    v0_base = v0_cnt;
    rd_en0  = 1'b1;
    repeat (16) @(posedge rd_clk);
    #1;
    chk("drain_empty", empty0, 1'b1);
    @(posedge rd_clk);
    #1;
    rd_en0 = 1'b0;
    chk("udf_pulse", underflow0, 1'b1);
    chk("udf_valid", rd_valid0, 1'b0);
    chk("udf_data", rd_data0, fill_d[16]);
    chk("udf_rlvl", rd_level0, 0);
    chk("udf_aempty", almost_empty0, 1'b1);
    @(posedge rd_clk);
    #1;
    chk("udf_end", underflow0, 1'b0);
    chk("drain_pops", v0_cnt - v0_base, 16);
    chk("drain_left", q0.size(), 0);

    // Three stored entries, separated single pops
    for (int i = 0; i < 3; i++) begin
      w0($urandom, acc);
    end
    for (k = 0; k < 40 && rd_level0 != 3; k++) begin
      @(posedge rd_clk);
      #1;
    end
    chk("three_rlvl", rd_level0, 3);
    v0_base = v0_cnt;
    for (int i = 0; i < 3; i++) begin
      @(posedge rd_clk);
      #1;
      rd_en0 = 1'b1;
      @(posedge rd_clk);
      #1;
      rd_en0 = 1'b0;
      chk("pop_valid_on", rd_valid0, 1'b1);
      @(posedge rd_clk);
      #1;
      chk("pop_valid_off", rd_valid0, 1'b0);
    end
    chk("three_pops", v0_cnt - v0_base, 3);

    // FWFT first-word latency
    chk("fw_pre_empty", empty, 1'b1);
    w1(32'hA5A5_0001, acc);
    found = 0;
    for (k = 1; k <= SYNC + 2 && found == 0; k++) begin
      @(posedge rd_clk);
      #1;
      if (rd_valid) found = 1;
    end
    chk("fw_latency", found, 1);
    chk("fw_data", rd_data, 32'hA5A5_0001);
    chk("fw_empty", empty, 1'b0);
    pop1("fw_pop");
    @(posedge rd_clk);
    #1;
    chk("fw_post_empty", empty, 1'b1);
    chk("fw_left", q1.size(), 0);

    // Reset with 7 entries stored
    for (int i = 0; i < 7; i++) begin
      w1(32'h0BAD_0000 + i, acc);
    end
    repeat (10) @(posedge rd_clk);
    #1;
    chk("pre_rst_valid", rd_valid, 1'b1);
    @(negedge wr_clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_full", full, 1'b0);
    chk("mid_rst_afull", almost_full, 1'b0);
    chk("mid_rst_wlvl", wr_level, 0);
    chk("mid_rst_ovf", overflow, 1'b0);
    chk("mid_rst_empty", empty, 1'b1);
    chk("mid_rst_aempty", almost_empty, 1'b1);
    chk("mid_rst_rlvl", rd_level, 0);
    chk("mid_rst_rdata", rd_data, 0);
    chk("mid_rst_valid", rd_valid, 1'b0);
    chk("mid_rst_udf", underflow, 1'b0);
    q1.delete();
    q0.delete();
    #23;
    reset_n = 1'b1;
    repeat (10) @(posedge rd_clk);
    #1;
    chk("post_rst_empty", empty, 1'b1);
    chk("post_rst_valid", rd_valid, 1'b0);
    w1(32'h5EED_0001, acc);
    pop1("post_rst_pop");
    @(posedge rd_clk);
    #1;
    chk("post_rst_left", q1.size(), 0);

    // Random streaming, fast writer then fast reader
    run_stream(1000, 32'h1000_0000);
    wr_half = 13.5;
    rd_half = 5.0;
    run_stream(1000, 32'h2000_0000);
    repeat (10) @(posedge rd_clk);
    #1;
    chk("end_empty", empty, 1'b1);
    chk("end_rlvl", rd_level, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
